// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants, opcodes and the fetch buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry sync FIFO of {instr, pc}; clk/rst, push/din, pop/head, flush, count
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic rd_ptr, wr_ptr, do_pop;
  always_comb begin
    do_pop = pop & (count != 2'd0);
    head = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end
  assert property (@(posedge clk) disable iff (rst) (push && !flush) |-> count != 2'd2);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem issue/kill and 2-entry buffer feeding decode via valid/ready; redirect from execute
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);
  logic [XLEN-1:0] pc, req_pc;
  logic inflight, pop, push;
  logic [1:0] count;
  logic [2:0] level;
  fetch_entry_t head;
  always_comb begin
    instr_valid = ~rst & (count != 2'd0);
    pop = instr_valid & instr_ready;
    push = inflight & ~redirect_valid;
    level = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    imem_req = ~rst & (redirect_valid | (level < 3'(DEPTH)));
    imem_addr = rst ? '0 : redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc;
    instr = instr_valid ? head.instr : '0;
    instr_pc = instr_valid ? head.pc : '0;
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= imem_addr;
        pc <= imem_addr + 32'd4;
      end
    end
  end
  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{instr: imem_rdata, pc: req_pc}),
    .head  (head),
    .count (count)
  );
endmodule
